// File: rtl/sdm_pkg.sv
// Shared definitions for the sensor delta monitor: event field widths and
// the channel-index width derivation used by the top, FIFO and interface.
package sdm_pkg;

  localparam int UP_W = 1;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int ev_w(input int data_w, input int chw);
    return chw + data_w + UP_W;
  endfunction

endpackage

// File: rtl/sensor_delta_monitor_if.sv
// Sample input bus and event output handshake of the sensor delta monitor.
// The slave side is the monitor; the master side produces samples and consumes events.
interface sensor_delta_monitor_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
);
  import sdm_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;

  logic              ev_valid;
  logic              ev_ready;
  logic [CH_W-1:0]   ev_ch;
  logic [DATA_W-1:0] ev_data;
  logic              ev_up;

  modport master (
    output in_valid, in_ch, in_data, ev_ready,
    input  ev_valid, ev_ch, ev_data, ev_up
  );

  modport slave (
    input  in_valid, in_ch, in_data, ev_ready,
    output ev_valid, ev_ch, ev_data, ev_up
  );

endinterface

// File: rtl/sdm_event_fifo.sv
// Event FIFO: power-of-two depth, registered pointers and occupancy count.
// A push while full succeeds only when a pop happens in the same cycle.
module sdm_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == DEPTH_L);
    rd_en     = pop & not_empty;
    wr_en     = push & (~full | rd_en);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Head reads zero while empty so stale storage never leaks to the consumer.
    head_data = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sensor_delta_monitor.sv
// Per-channel change detector: compares each sample against the channel's last
// reported value and queues an event when the absolute change exceeds thresh.
module sensor_delta_monitor
  import sdm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sensor_delta_monitor_if.slave bus,
  input  logic [DATA_W-1:0]     thresh,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  clr,
  output logic [NUM_CH-1:0]     alarm,
  output logic                  ovf
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int EV_W = ev_w(DATA_W, CH_W);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [DATA_W-1:0] chan_ref_q [NUM_CH];
  logic [DATA_W-1:0] chan_ref_d [NUM_CH];
  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic              ovf_q, ovf_d;

  logic              in_range;
  logic              ch_on;
  logic [DATA_W-1:0] sel_ref;
  logic [DATA_W-1:0] diff;
  logic              change;
  logic              rise;
  logic              pop;
  logic              drop;
  logic [EV_W-1:0]   push_data;
  logic [EV_W-1:0]   head_data;
  logic              fifo_valid;
  logic              fifo_full;

  always_comb begin
    in_range = ({1'b0, bus.in_ch} < NUM_CH_L);
    sel_ref  = '0;
    ch_on    = 1'b0;
    if (in_range) begin
      sel_ref = chan_ref_q[bus.in_ch];
      ch_on   = ch_en[bus.in_ch];
    end

    diff      = abs_diff(bus.in_data, sel_ref);
    change    = bus.in_valid & ch_on & (diff > thresh);
    rise      = (bus.in_data > sel_ref);
    push_data = {bus.in_ch, bus.in_data, rise};

    // A full FIFO still accepts the push when the head leaves the same cycle.
    pop  = fifo_valid & bus.ev_ready;
    drop = change & fifo_full & ~pop;

    chan_ref_d = chan_ref_q;
    alarm_d    = clr ? '0 : alarm_q;
    ovf_d      = (ovf_q & ~clr) | drop;
    if (change) begin
      chan_ref_d[bus.in_ch] = bus.in_data;
      alarm_d[bus.in_ch]    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        chan_ref_q[c] <= '0;
      end
      alarm_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      chan_ref_q <= chan_ref_d;
      alarm_q    <= alarm_d;
      ovf_q      <= ovf_d;
    end
  end

  sdm_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (change),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .not_empty (fifo_valid),
    .full      (fifo_full)
  );

  assign bus.ev_valid = fifo_valid;
  assign {bus.ev_ch, bus.ev_data, bus.ev_up} = head_data;
  assign alarm = alarm_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_sensor_delta_monitor.sv
// Directed bench for sensor_delta_monitor: a vector table for single-cycle
// behaviour plus hand-written sequences for overflow, pop/push and reset.
module tb_sensor_delta_monitor;

  localparam int DATA_W     = 8;
  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] thresh;
  logic [NUM_CH-1:0] ch_en;
  logic              clr;
  logic [NUM_CH-1:0] alarm;
  logic              ovf;

  int n_chk  = 0;
  int n_fail = 0;

  sensor_delta_monitor_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  sensor_delta_monitor #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .thresh (thresh),
    .ch_en  (ch_en),
    .clr    (clr),
    .alarm  (alarm),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [7:0] d;
    logic [7:0] th;
    logic [3:0] en;
    logic       rdy;
    logic       clr;
    logic       e_v;
    logic [1:0] e_ch;
    logic [7:0] e_d;
    logic       e_up;
    logic [3:0] e_al;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input string nm, input logic v, input logic [1:0] ch,
                        input logic [7:0] d, input logic up);
    chk({nm, "_vld"},  32'(bus.ev_valid), 32'(v));
    chk({nm, "_ch"},   32'(bus.ev_ch),    32'(ch));
    chk({nm, "_data"}, 32'(bus.ev_data),  32'(d));
    chk({nm, "_up"},   32'(bus.ev_up),    32'(up));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [1:0] ch, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input logic [1:0] chs [4],
                       input logic [7:0] ds [4], input logic ups [4]);
    for (int i = 0; i < 4; i++) begin
      chk_ev($sformatf("%s_%0d", nm, i), 1'b1, chs[i], ds[i], ups[i]);
      bus.ev_ready = 1'b1;
      step();
      bus.ev_ready = 1'b0;
    end
    chk_ev({nm, "_empty"}, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  initial begin
    logic [1:0] chs [4];
    logic [7:0] ds  [4];
    logic       ups [4];

    //          v  ch  d    th   en     rdy clr  e_v e_ch e_d  up  alarm  ovf
    vecs[0]  = '{1, 2, 10,  2,   4'hF,  0,  0,   1,  2,   10,  1,  4'h4,  0};
    vecs[1]  = '{1, 2, 12,  2,   4'hF,  0,  0,   1,  2,   10,  1,  4'h4,  0};
    vecs[2]  = '{1, 2, 12,  2,   4'hF,  1,  0,   0,  0,   0,   0,  4'h4,  0};
    vecs[3]  = '{1, 0, 200, 2,   4'hE,  0,  0,   0,  0,   0,   0,  4'h4,  0};
    vecs[4]  = '{1, 0, 200, 2,   4'hF,  0,  0,   1,  0,   200, 1,  4'h5,  0};
    vecs[5]  = '{0, 0, 0,   2,   4'hF,  1,  0,   0,  0,   0,   0,  4'h5,  0};
    vecs[6]  = '{1, 3, 1,   0,   4'hF,  0,  0,   1,  3,   1,   1,  4'hD,  0};
    vecs[7]  = '{1, 3, 255, 255, 4'hF,  1,  0,   0,  0,   0,   0,  4'hD,  0};
    vecs[8]  = '{1, 1, 50,  3,   4'hF,  0,  0,   1,  1,   50,  1,  4'hF,  0};
    vecs[9]  = '{1, 1, 40,  3,   4'hF,  1,  0,   1,  1,   40,  0,  4'hF,  0};
    vecs[10] = '{0, 0, 0,   3,   4'hF,  1,  1,   0,  0,   0,   0,  4'h0,  0};
    vecs[11] = '{1, 1, 0,   0,   4'h0,  0,  0,   0,  0,   0,   0,  4'h0,  0};
    vecs[12] = '{1, 1, 43,  3,   4'hF,  0,  0,   0,  0,   0,   0,  4'h0,  0};
    vecs[13] = '{1, 1, 44,  3,   4'hF,  0,  0,   1,  1,   44,  1,  4'h2,  0};
    vecs[14] = '{0, 0, 0,   3,   4'hF,  1,  0,   0,  0,   0,   0,  4'h2,  0};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.in_data  = '0;
    bus.ev_ready = 1'b0;
    thresh       = 8'd2;
    ch_en        = 4'hF;
    clr          = 1'b0;

    repeat (2) step();
    chk_ev("rst", 1'b0, 2'd0, 8'd0, 1'b0);
    chk("rst_alarm", 32'(alarm), 32'h0);
    chk("rst_ovf",   32'(ovf),   32'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      bus.in_valid = vecs[i].v;
      bus.in_ch    = vecs[i].ch;
      bus.in_data  = vecs[i].d;
      thresh       = vecs[i].th;
      ch_en        = vecs[i].en;
      bus.ev_ready = vecs[i].rdy;
      clr          = vecs[i].clr;
      step();
      chk_ev($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_ch, vecs[i].e_d, vecs[i].e_up);
      chk($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vecs[i].e_al));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].e_ovf));
    end
    bus.in_valid = 1'b0;
    bus.ev_ready = 1'b0;
    clr          = 1'b0;
    ch_en        = 4'hF;
    thresh       = 8'd0;

    // Overflow: refs are ch0=200 ch1=44 ch2=10 ch3=1; five changes, no pops.
    sample(2'd0, 8'd10);
    sample(2'd1, 8'd20);
    sample(2'd2, 8'd30);
    sample(2'd3, 8'd40);
    chk("ovf_full_ovf", 32'(ovf), 32'h0);
    sample(2'd0, 8'd50);
    chk("ovf_drop_ovf",   32'(ovf),   32'h1);
    chk("ovf_drop_alarm", 32'(alarm), 32'hF);
    chs = '{2'd0, 2'd1, 2'd2, 2'd3};
    ds  = '{8'd10, 8'd20, 8'd30, 8'd40};
    ups = '{1'b0, 1'b0, 1'b1, 1'b1};
    drain("ovf_drain", chs, ds, ups);
    chk("ovf_sticky", 32'(ovf), 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_alarm", 32'(alarm), 32'h0);
    chk("clr_ovf",   32'(ovf),   32'h0);

    // Full FIFO with a pop and a push in the same cycle; refs ch0=50 ch1=20 ch2=30 ch3=40.
    sample(2'd0, 8'd60);
    sample(2'd1, 8'd10);
    sample(2'd2, 8'd31);
    sample(2'd3, 8'd39);
    chk("pp_full_ovf", 32'(ovf), 32'h0);
    bus.ev_ready = 1'b1;
    sample(2'd0, 8'd70);
    bus.ev_ready = 1'b0;
    chk("pp_ovf", 32'(ovf), 32'h0);
    chs = '{2'd1, 2'd2, 2'd3, 2'd0};
    ds  = '{8'd10, 8'd31, 8'd39, 8'd70};
    ups = '{1'b0, 1'b1, 1'b0, 1'b1};
    drain("pp_drain", chs, ds, ups);
    chk("pp_alarm", 32'(alarm), 32'hF);

    // clr coinciding with a change: the changed channel keeps its alarm.
    clr = 1'b1;
    sample(2'd2, 8'd100);
    clr = 1'b0;
    chk("clrwin_alarm", 32'(alarm), 32'h4);
    chk_ev("clrwin_ev", 1'b1, 2'd2, 8'd100, 1'b1);
    bus.ev_ready = 1'b1;
    step();
    bus.ev_ready = 1'b0;
    chk("clrwin_empty", 32'(bus.ev_valid), 32'h0);

    // Asynchronous reset mid-cycle with three events queued.
    sample(2'd0, 8'd1);
    sample(2'd1, 8'd2);
    sample(2'd2, 8'd3);
    chk("ar_queued", 32'(bus.ev_valid), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk_ev("ar_async", 1'b0, 2'd0, 8'd0, 1'b0);
    chk("ar_alarm", 32'(alarm), 32'h0);
    chk("ar_ovf",   32'(ovf),   32'h0);
    step();
    reset  = 1'b0;
    thresh = 8'd4;
    sample(2'd0, 8'd3);
    chk("ar_ref0", 32'(bus.ev_valid), 32'h0);
    sample(2'd1, 8'd5);
    chk_ev("ar_ref1", 1'b1, 2'd1, 8'd5, 1'b1);
    chk("ar_ref1_alarm", 32'(alarm), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_delta_monitor.md
SENSOR_DELTA_MONITOR -- requirements
Module: sensor_delta_monitor

Interface
REQ-001 Parameter DATA_W, default 8, sample and reference width in bits.
REQ-002 Parameter NUM_CH, default 4, number of sensor channels (2..16).
REQ-003 Parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-004 Clocking SHALL be: reset reset, asynchronous, active-high; clock clk.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  sample present this cycle; always accepted, no backpressure.
REQ-008 in_ch  input  CH_W=max(1,clog2(NUM_CH))  channel index of the sample.
REQ-009 in_data  input  DATA_W  sample value.
REQ-010 thresh  input  DATA_W  change threshold, sampled every cycle.
REQ-011 ch_en  input  NUM_CH  per-channel enable mask.
REQ-012 clr  input  1  synchronous clear of the alarm and ovf sticky flags.
REQ-013 ev_valid  output  1  FIFO head event available.
REQ-014 ev_ready  input  1  consumer accepts the head event when ev_valid is high.
REQ-015 ev_ch / ev_data / ev_up  output  CH_W / DATA_W / 1  head event channel, new value, direction (1 = rise).
REQ-016 alarm  output  NUM_CH  per-channel sticky change flags.
REQ-017 ovf  output  1  sticky flag: an event was dropped.

Function
REQ-018 Per-channel reference register ref[c], DATA_W bits, reset value 0.
REQ-019 On an accepted sample, diff SHALL be |in_data - ref[in_ch]| computed without wrap (larger minus smaller), DATA_W bits.
REQ-020 A sample SHALL be a change when in_valid=1, in_ch<NUM_CH, ch_en[in_ch]=1 and diff > thresh (strict).
REQ-021 On a change, ref[in_ch] <= in_data, alarm[in_ch] <= 1, and event {in_ch, in_data, in_data>ref} is pushed.
REQ-022 Non-change samples (diff <= thresh, disabled channel, in_ch >= NUM_CH) SHALL alter no state.
REQ-023 Latency: an event pushed into an empty FIFO SHALL appear with ev_valid=1 on the cycle after the sample.
REQ-024 Pop SHALL occur on ev_valid & ev_ready; outputs SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-025 FIFO order SHALL be strict first-in first-out.
REQ-026 Full FIFO with no pop: event dropped, ovf <= 1, ref and alarm still updated.
REQ-027 Full FIFO with pop in the same cycle: push SHALL succeed, nothing dropped.
REQ-028 clr SHALL zero alarm and ovf next cycle; a same-cycle change or drop SHALL win (flag remains/becomes 1).
REQ-029 thresh = all-ones SHALL suppress all changes; thresh = 0 SHALL flag any nonzero difference.

Reset
REQ-030 Reset SHALL clear all ref to 0, empty the FIFO (ev_valid=0), and clear alarm and ovf to 0.
REQ-031 ev_ch, ev_data and ev_up SHALL read 0 during and after reset until the first push.
REQ-032 Reset asserted mid-operation SHALL discard pending events immediately, without waiting for a clock edge.

Structure
REQ-033 Shared package sdm_pkg SHALL hold the event field width localparams and the CH_W derivation.
REQ-034 The FIFO SHALL be sub-module sdm_event_fifo (parametrised width/depth, registered pointers, count).
REQ-035 Comparator/update logic SHALL live in sensor_delta_monitor.

Verification
REQ-036 After reset, ch2 samples 10 then 12 with thresh=2 -> 10 yields an event (ch2, 10, up=1) one cycle later; 12 yields no event; ref[2]=10.
REQ-037 ch_en=4'b1110, ch0 sample 200 -> no event, alarm=0; enable ch0 and resend 200 -> event, alarm[0]=1.
REQ-038 ev_ready=0, five changes with FIFO_DEPTH=4 -> four events are retained, the fifth is dropped, ovf=1; drain order matches input order.
REQ-039 FIFO full; a change arrives in the same cycle as a pop -> no drop, ovf remains 0, count remains 4.
REQ-040 ch1 ref=50, sample 40 with thresh=3 -> event up=0, data 40; then clr pulse -> alarm[1]=0, ovf=0.
REQ-041 Assert reset with 3 events queued -> ev_valid=0 and alarm=0 immediately; ref values read back as 0 via the next change detection.
